// File: rtl/id_control_unit_pkg.sv
// Shared definitions for the ID-stage control unit of the 16-bit pipeline:
// opcode encodings, ALUOp encodings, instruction field positions, the
// ID/EX control bundle and a small helper that classifies rt usage.
package id_control_unit_pkg;

    localparam int CPU_INSTR_W = 16;
    localparam int CPU_REG_AW  = 3;

    // Instruction field positions: [15:12] op, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] funct
    localparam int OPC_MSB   = 15;
    localparam int RS_MSB    = 11;
    localparam int RT_MSB    = 8;
    localparam int RD_MSB    = 5;
    localparam int FUNCT_MSB = 2;

    // Opcodes; everything from 4'h6 upward is illegal
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;

    // ALUOp encodings consumed by the EX-stage ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // Control bundle held in the ID/EX register
    typedef struct packed {
        logic                  valid;
        logic [1:0]            aluop;
        logic [2:0]            funct;
        logic                  alusrc;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem2reg;
        logic                  branch;
        logic                  jump;
        logic [CPU_REG_AW-1:0] wreg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(16'h0000);

    // Opcodes that read rt as a source operand (R-type, sw, beq)
    function automatic logic op_uses_rt(input logic [3:0] op);
        logic uses;
        case (op)
            OP_RTYPE: uses = 1'b1;
            OP_SW:    uses = 1'b1;
            OP_BEQ:   uses = 1'b1;
            default:  uses = 1'b0;
        endcase
        return uses;
    endfunction

endpackage

// File: rtl/id_control_unit_control_decode.sv
// Purely combinational opcode -> control bundle decoder. Illegal opcodes
// produce a bubble bundle and raise illegal_o; the caller decides what to
// do with the flag.
module id_control_unit_control_decode
    import id_control_unit_pkg::*;
(
    input  logic [CPU_INSTR_W-1:0] instr_i,
    output ctrl_t                  ctrl_o,
    output logic                   illegal_o
);

    logic [3:0]            op_s;
    logic [CPU_REG_AW-1:0] rt_s;
    logic [CPU_REG_AW-1:0] rd_s;
    logic [2:0]            funct_s;

    assign op_s    = instr_i[OPC_MSB -: 4];
    assign rt_s    = instr_i[RT_MSB -: CPU_REG_AW];
    assign rd_s    = instr_i[RD_MSB -: CPU_REG_AW];
    assign funct_s = instr_i[FUNCT_MSB -: 3];

    // Opcode table; non-writing instructions leave wreg at zero
    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        illegal_o = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.aluop     = ALUOP_FUNCT;
                ctrl_o.funct     = funct_s;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wreg      = rd_s;
            end
            OP_ADDI: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.aluop     = ALUOP_ADD;
                ctrl_o.funct     = funct_s;
                ctrl_o.alusrc    = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wreg      = rt_s;
            end
            OP_LW: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.aluop     = ALUOP_ADD;
                ctrl_o.funct     = funct_s;
                ctrl_o.alusrc    = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem2reg   = 1'b1;
                ctrl_o.wreg      = rt_s;
            end
            OP_SW: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.aluop     = ALUOP_ADD;
                ctrl_o.funct     = funct_s;
                ctrl_o.alusrc    = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.aluop     = ALUOP_SUB;
                ctrl_o.funct     = funct_s;
                ctrl_o.branch    = 1'b1;
            end
            OP_J: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.aluop     = ALUOP_ADD;
                ctrl_o.funct     = funct_s;
                ctrl_o.jump      = 1'b1;
            end
            default: begin
                ctrl_o    = CTRL_BUBBLE;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_control_unit.sv
// ID-stage main control: decodes the IF/ID instruction, detects load-use
// hazards against the instruction in ID/EX, applies flush > hazard > normal
// priority and registers the result into the ID/EX control register.
// Optional feature macro: ILLEGAL_TRAP_EN (sticky illegal-opcode flag).
module id_control_unit
    import id_control_unit_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               in_valid,
    input  logic               flush,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic [1:0]         ex_aluop,
    output logic [2:0]         ex_funct,
    output logic               ex_alusrc,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem2reg,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [REG_AW-1:0]  ex_wreg,
    output logic               illegal_flag
);

    ctrl_t             dec_s;
    logic              dec_illegal_s;
    ctrl_t             ex_q;
    ctrl_t             ex_d;
    logic              raw_s;
    logic [3:0]        op_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;

    assign op_s = instr[OPC_MSB -: 4];
    assign rs_s = instr[RS_MSB -: REG_AW];
    assign rt_s = instr[RT_MSB -: REG_AW];

    id_control_unit_control_decode u_decode (
        .instr_i   (instr),
        .ctrl_o    (dec_s),
        .illegal_o (dec_illegal_s)
    );

    // Load-use hazard: the load in EX writes a register this instruction reads
    always_comb begin
        raw_s = 1'b0;
        if (ex_q.valid && ex_q.mem_read && in_valid) begin
            raw_s = (ex_q.wreg == rs_s) || ((ex_q.wreg == rt_s) && op_uses_rt(op_s));
        end else begin
            raw_s = 1'b0;
        end
    end

    // A flush squashes the instruction, so there is nothing left to hold
    assign hazard_stall = raw_s & ~flush;

    // Next ID/EX contents: flush > load-use bubble > idle/illegal bubble > decode
    always_comb begin
        ex_d = CTRL_BUBBLE;
        if (flush) begin
            ex_d = CTRL_BUBBLE;
        end else if (raw_s) begin
            ex_d = CTRL_BUBBLE;
        end else if (!in_valid || dec_illegal_s) begin
            ex_d = CTRL_BUBBLE;
        end else begin
            ex_d = dec_s;
        end
    end

    // ID/EX control register; reset clears it immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q <= CTRL_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    // Sticky flag: set by an illegal opcode that would otherwise have issued
    always_comb begin
        illegal_d = illegal_q;
        if (in_valid && !flush && !raw_s && dec_illegal_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Illegal flag register, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_flag = illegal_q;
`else
    assign illegal_flag = 1'b0;
`endif

    assign ex_valid     = ex_q.valid;
    assign ex_aluop     = ex_q.aluop;
    assign ex_funct     = ex_q.funct;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem2reg   = ex_q.mem2reg;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_wreg      = ex_q.wreg;

endmodule

// File: tb/tb_id_control_unit.sv
// Self-checking bench for id_control_unit: an independent reference model
// predicts the ID/EX contents, expected bundles are queued when stimulus is
// driven and compared after the clock edge.
module tb_id_control_unit;

    logic        clock;
    logic        reset;
    logic [15:0] instr;
    logic        in_valid;
    logic        flush;
    logic        hazard_stall;
    logic        ex_valid;
    logic [1:0]  ex_aluop;
    logic [2:0]  ex_funct;
    logic        ex_alusrc;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem2reg;
    logic        ex_branch;
    logic        ex_jump;
    logic [2:0]  ex_wreg;
    logic        illegal_flag;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Bundle layout: {valid, aluop[2], funct[3], alusrc, mr, mw, rw, m2r, br, j, wreg[3]}
    logic [15:0] model_ex;
    logic        model_ill;
    logic        exp_stall;
    logic [15:0] exp_q[$];
    logic [15:0] obs;

    id_control_unit dut (
        .clock        (clock),
        .reset        (reset),
        .instr        (instr),
        .in_valid     (in_valid),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .ex_valid     (ex_valid),
        .ex_aluop     (ex_aluop),
        .ex_funct     (ex_funct),
        .ex_alusrc    (ex_alusrc),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_reg_write (ex_reg_write),
        .ex_mem2reg   (ex_mem2reg),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .ex_wreg      (ex_wreg),
        .illegal_flag (illegal_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs = {ex_valid, ex_aluop, ex_funct, ex_alusrc, ex_mem_read, ex_mem_write,
                  ex_reg_write, ex_mem2reg, ex_branch, ex_jump, ex_wreg};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode table
    function automatic logic [15:0] ref_decode(input logic [15:0] ins);
        logic [2:0] f;
        logic [2:0] rt;
        logic [2:0] rd;
        f  = ins[2:0];
        rt = ins[8:6];
        rd = ins[5:3];
        case (ins[15:12])
            4'h0:    return {1'b1, 2'b10, f, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rd};
            4'h1:    return {1'b1, 2'b00, f, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rt};
            4'h2:    return {1'b1, 2'b00, f, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rt};
            4'h3:    return {1'b1, 2'b00, f, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
            4'h4:    return {1'b1, 2'b01, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
            4'h5:    return {1'b1, 2'b00, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic ref_raw(input logic [15:0] ex, input logic [15:0] ins, input logic v);
        logic uses_rt;
        uses_rt = (ins[15:12] == 4'h0) || (ins[15:12] == 4'h3) || (ins[15:12] == 4'h4);
        return ex[15] && ex[8] && v &&
               ((ex[2:0] == ins[11:9]) || ((ex[2:0] == ins[8:6]) && uses_rt));
    endfunction

    // One clock: drive, check hazard, queue prediction, compare after the edge
    task automatic cycle(input logic [15:0] ins, input logic v, input logic f);
        logic        raw;
        logic [15:0] nxt;
        logic [15:0] exp_b;
        instr    = ins;
        in_valid = v;
        flush    = f;
        #1;
        raw       = ref_raw(model_ex, ins, v);
        exp_stall = raw & ~f;
        check_eq("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_stall});
        if (f || raw || !v) nxt = 16'h0000;
        else                nxt = ref_decode(ins);
`ifdef ILLEGAL_TRAP_EN
        if (v && !f && !raw && (ins[15:12] >= 4'h6)) model_ill = 1'b1;
`endif
        exp_q.push_back(nxt);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp_b    = exp_q.pop_front();
            model_ex = exp_b;
            check_eq("ex_bundle", {16'd0, obs}, {16'd0, exp_b});
        end
        check_eq("illegal_flag", {31'd0, illegal_flag}, {31'd0, model_ill});
    endtask

    initial begin
        logic [15:0] r_ins;
        logic        r_v;
        logic        r_f;
        logic [3:0]  op_tab [0:6];
        op_tab[0] = 4'h0; op_tab[1] = 4'h1; op_tab[2] = 4'h2; op_tab[3] = 4'h2;
        op_tab[4] = 4'h3; op_tab[5] = 4'h4; op_tab[6] = 4'h5;

        model_ex  = 16'h0000;
        model_ill = 1'b0;
        reset     = 1'b1;
        instr     = 16'h0000;
        in_valid  = 1'b1;
        flush     = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_eq("reset_bundle", {16'd0, obs}, 32'd0);
        check_eq("reset_stall", {31'd0, hazard_stall}, 32'd0);
        check_eq("reset_illegal", {31'd0, illegal_flag}, 32'd0);
        reset = 1'b0;

        // First edge after release loads the R-type
        cycle(16'h0000, 1'b1, 1'b0);
        check_eq("first_aluop", {30'd0, ex_aluop}, 32'd2);
        check_eq("first_regwrite", {31'd0, ex_reg_write}, 32'd1);

        // R-type rs=5 rt=1 rd=3 funct=010
        cycle(16'h0A5A, 1'b1, 1'b0);
        check_eq("rtype_funct", {29'd0, ex_funct}, 32'd2);
        check_eq("rtype_wreg", {29'd0, ex_wreg}, 32'd3);
        check_eq("rtype_alusrc", {31'd0, ex_alusrc}, 32'd0);

        // Load-use pair: one stall, one bubble, then the add issues
        cycle(16'h2280, 1'b1, 1'b0);
        cycle(16'h0458, 1'b1, 1'b0);
        check_eq("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        cycle(16'h0458, 1'b1, 1'b0);
        check_eq("lu_stall_released", {31'd0, exp_stall}, 32'd0);
        check_eq("lu_add_aluop", {30'd0, ex_aluop}, 32'd2);
        check_eq("lu_add_valid", {31'd0, ex_valid}, 32'd1);

        // Same pair with flush in the hazard cycle
        cycle(16'h2280, 1'b1, 1'b0);
        cycle(16'h0458, 1'b1, 1'b1);
        check_eq("flush_bubble", {16'd0, obs}, 32'd0);

        // beq
        cycle(16'h4280, 1'b1, 1'b0);
        check_eq("beq_aluop", {30'd0, ex_aluop}, 32'd1);
        check_eq("beq_branch", {31'd0, ex_branch}, 32'd1);
        check_eq("beq_regwrite", {31'd0, ex_reg_write}, 32'd0);

        // Illegal opcode becomes a bubble; flag (if enabled) sticks
        cycle(16'hF000, 1'b1, 1'b0);
        check_eq("illegal_bubble", {16'd0, obs}, 32'd0);
        cycle(16'h1047, 1'b1, 1'b0);
        cycle(16'h5000, 1'b1, 1'b0);
        cycle(16'h3123, 1'b0, 1'b0);

        // Randomised traffic with hazards re-presented while stalled
        r_ins = 16'h0000;
        r_v   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!exp_stall) begin
                r_ins = {op_tab[$urandom_range(6, 0)], 3'($urandom_range(3, 0)),
                         3'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
                         3'($urandom_range(7, 0))};
                if ($urandom_range(19, 0) == 0) r_ins[15:12] = 4'($urandom_range(15, 6));
                r_v = ($urandom_range(9, 0) != 0);
            end
            r_f = ($urandom_range(9, 0) == 0);
            cycle(r_ins, r_v, r_f);
        end

        // Asynchronous reset mid-operation clears ID/EX at once
        cycle(16'h2280, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset_bundle", {16'd0, obs}, 32'd0);
        check_eq("async_reset_illegal", {31'd0, illegal_flag}, 32'd0);
        check_eq("async_reset_stall", {31'd0, hazard_stall}, 32'd0);
        model_ex  = 16'h0000;
        model_ill = 1'b0;
        exp_stall = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(16'h0458, 1'b1, 1'b0);
        cycle(16'h1000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
